gas_zone_ctrl: RTL and testbench

- Multi-zone hazardous-gas supervisory controller; next generation of the single-sensor gas FSM.
- Sits between N zone sensor pairs (gas, temperature), the shared plant status inputs (mains power, fan current, airflow, RFID reset) and the actuator drivers.
- Adds per-zone debounce, a latched zone-of-origin mask, a fan spin-up grace window and timed escalation of the remote alert.

---
 rtl/gas_zone_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gas_zone_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gas_zone_ctrl.sv
// ---------------------------------------------------------------------------
// gas_zone_ctrl
// Multi-zone hazardous-gas supervisory controller. Each zone's gas and
// temperature sensors are debounced into a filtered hazard bit. A Moore FSM
// uses the filtered hazards, mains power, fan current and airflow to drive
// the ventilation, shut-off and alarm actuators.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   gas_ok[N]       per-zone gas sensor, 1 = safe
//   temp_ok[N]      per-zone temperature sensor, 1 = safe
//   pwr_ok          mains present
//   fan_ok          fan current nominal
//   flow_ok         airflow nominal
//   rfid_ok         authorised reset badge present
//   fan, backup, valve, local_alarm, remote_alert, visual_alarm
//                   actuator drivers, decoded from the state alone
//   zone_mask[N]    zones that reported a filtered hazard since the last
//                   authorised reset
//   state[3]        current FSM state, for logging
// ---------------------------------------------------------------------------
module gas_zone_ctrl #(
    parameter int N_ZONES    = 4,
    parameter int DEBOUNCE   = 8,
    parameter int FAN_GRACE  = 16,
    parameter int ESC_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] gas_ok,
    input  logic [N_ZONES-1:0] temp_ok,
    input  logic               pwr_ok,
    input  logic               fan_ok,
    input  logic               flow_ok,
    input  logic               rfid_ok,
    output logic               fan,
    output logic               backup,
    output logic               valve,
    output logic               local_alarm,
    output logic               remote_alert,
    output logic               visual_alarm,
    output logic [N_ZONES-1:0] zone_mask,
    output logic [2:0]         state
);

    localparam int CNT_W   = $clog2(DEBOUNCE + 1);
    localparam int GRACE_W = $clog2(FAN_GRACE + 1);
    localparam int ESC_W   = $clog2(ESC_CYCLES + 1);

    typedef enum logic [2:0] {
        STANDBY     = 3'b000,
        HAZARD      = 3'b001,
        FAULT_MIT   = 3'b010,
        WAIT_RESET  = 3'b011,
        FAILSAFE_PF = 3'b100,
        HAZARD_PF   = 3'b101
    } stateT;

    stateT stateQ, stateD;

    logic [CNT_W-1:0]   dbCnt [N_ZONES];
    logic [N_ZONES-1:0] raw, filt;
    logic [GRACE_W-1:0] graceCnt;
    logic [ESC_W-1:0]   escCnt;
    logic               escFlag;
    logic               haz, safe, pf, mf, graceExpired;
    logic               enterHazard, enterStandby, escCounting;
    logic [5:0]         outVec;

    assign raw          = ~gas_ok | ~temp_ok;
    assign haz          = |filt;
    assign safe         = ~haz;
    assign pf           = ~pwr_ok;
    assign mf           = ~fan_ok | ~flow_ok;
    assign graceExpired = (graceCnt == GRACE_W'(FAN_GRACE));

    // Per-zone debounce: filt follows raw only after DEBOUNCE consecutive
    // edges that all sample a level different from the current filt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ZONES; i++) dbCnt[i] <= '0;
            filt <= '0;
        end else begin
            for (int i = 0; i < N_ZONES; i++) begin
                if (raw[i] == filt[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                    filt[i]  <= ~filt[i];
                    dbCnt[i] <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Next-state logic; within each state the checks are in priority order.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            STANDBY: begin
                if (pf)       stateD = FAILSAFE_PF;
                else if (haz) stateD = HAZARD;
            end
            HAZARD: begin
                if (pf)                     stateD = HAZARD_PF;
                else if (mf & graceExpired) stateD = FAULT_MIT;
                else if (safe)              stateD = WAIT_RESET;
            end
            FAULT_MIT: begin
                if (pf)        stateD = HAZARD_PF;
                else if (safe) stateD = WAIT_RESET;
            end
            WAIT_RESET: begin
                if (pf)                  stateD = FAILSAFE_PF;
                else if (rfid_ok & safe) stateD = STANDBY;
                else if (haz)            stateD = HAZARD;
            end
            FAILSAFE_PF: begin
                if (pwr_ok) stateD = STANDBY;
            end
            HAZARD_PF: begin
                if (pwr_ok) stateD = HAZARD;
            end
            default: stateD = STANDBY;
        endcase
    end

    assign enterHazard  = (stateD == HAZARD)  && (stateQ != HAZARD);
    assign enterStandby = (stateD == STANDBY) && (stateQ != STANDBY);
    assign escCounting  = (stateQ == HAZARD) || (stateQ == FAULT_MIT) ||
                          (stateQ == HAZARD_PF);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateQ <= STANDBY;
        else     stateQ <= stateD;
    end

    // Fan spin-up grace: restarts on every HAZARD entry (including the return
    // from HAZARD_PF) and saturates once the window has elapsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    graceCnt <= '0;
        else if (enterHazard)       graceCnt <= '0;
        else if (!graceExpired)     graceCnt <= graceCnt + GRACE_W'(1);
    end

    // Escalation: counts hazard-class cycles, holds through WAIT_RESET and
    // power-fail, and only an arrival in STANDBY forgets the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            escCnt  <= '0;
            escFlag <= 1'b0;
        end else if (enterStandby) begin
            escCnt  <= '0;
            escFlag <= 1'b0;
        end else if (escCounting) begin
            if (escCnt == ESC_W'(ESC_CYCLES - 1)) escFlag <= 1'b1;
            else                                  escCnt  <= escCnt + ESC_W'(1);
        end
    end

    // Zone-of-origin mask accumulates until the badge reset out of
    // WAIT_RESET; a power-fail excursion keeps it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          zone_mask <= '0;
        else if ((stateQ == WAIT_RESET) && enterStandby)  zone_mask <= '0;
        else                                              zone_mask <= zone_mask | filt;
    end

    // Moore output decode: {fan, backup, valve, local, remote, visual}.
    always_comb begin
        outVec = 6'b000111;
        case (stateQ)
            STANDBY:     outVec = 6'b000000;
            HAZARD:      outVec = {4'b1011, escFlag, 1'b1};
            FAULT_MIT:   outVec = 6'b101111;
            WAIT_RESET:  outVec = {4'b0001, escFlag, 1'b1};
            FAILSAFE_PF: outVec = 6'b010000;
            HAZARD_PF:   outVec = 6'b111111;
            default:     outVec = 6'b000111;
        endcase
    end

    assign {fan, backup, valve, local_alarm, remote_alert, visual_alarm} = outVec;
    assign state = stateQ;

endmodule

// File: tb/tb_gas_zone_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gas_zone_ctrl
// Directed bench for gas_zone_ctrl with default parameters (4 zones,
// DEBOUNCE 8, FAN_GRACE 16, ESC_CYCLES 64). Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_gas_zone_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] gasOk, tempOk;
    logic       pwrOk, fanOk, flowOk, rfidOk;
    logic       fan, backup, valve, localAlarm, remoteAlert, visualAlarm;
    logic [3:0] zoneMask;
    logic [2:0] state;
    logic [5:0] outs;

    int checks;
    int failures;

    gas_zone_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .gas_ok       (gasOk),
        .temp_ok      (tempOk),
        .pwr_ok       (pwrOk),
        .fan_ok       (fanOk),
        .flow_ok      (flowOk),
        .rfid_ok      (rfidOk),
        .fan          (fan),
        .backup       (backup),
        .valve        (valve),
        .local_alarm  (localAlarm),
        .remote_alert (remoteAlert),
        .visual_alarm (visualAlarm),
        .zone_mask    (zoneMask),
        .state        (state)
    );

    assign outs = {fan, backup, valve, localAlarm, remoteAlert, visualAlarm};

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] gas, input logic [3:0] temp,
                                 input logic pwr, input logic fanI,
                                 input logic flow, input logic rfid);
        gasOk  = gas;
        tempOk = temp;
        pwrOk  = pwr;
        fanOk  = fanI;
        flowOk = flow;
        rfidOk = rfid;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(2);
        $display("[TB] reset state");
        checkOutput("rst_state", {5'd0, state}, 8'd0);
        checkOutput("rst_outs", {2'd0, outs}, 8'd0);
        checkOutput("rst_mask", {4'd0, zoneMask}, 8'd0);
        rst = 1'b0;

        // A 3-cycle glitch on zone 0 must be filtered out.
        applyStimulus(4'hE, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(3);
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(10);
        checkOutput("glitch_state", {5'd0, state}, 8'd0);
        checkOutput("glitch_mask", {4'd0, zoneMask}, 8'd0);

        // Zone 2 gas hazard: filt at edge 8, HAZARD at edge 9.
        $display("[TB] zone 2 hazard entry");
        applyStimulus(4'hB, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(7);
        checkOutput("deb7_mask", {4'd0, zoneMask}, 8'd0);
        tick(1);
        checkOutput("deb8_state", {5'd0, state}, 8'd0);
        tick(1);
        checkOutput("entry_state", {5'd0, state}, 8'd1);
        checkOutput("entry_outs", {2'd0, outs}, 8'b00101101);
        checkOutput("entry_mask", {4'd0, zoneMask}, 8'b00000100);

        // Power fail in HAZARD, then restore; mask survives.
        applyStimulus(4'hB, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("hazpf_state", {5'd0, state}, 8'd5);
        checkOutput("hazpf_outs", {2'd0, outs}, 8'b00111111);
        checkOutput("hazpf_mask", {4'd0, zoneMask}, 8'b00000100);
        applyStimulus(4'hB, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("pwrback_state", {5'd0, state}, 8'd1);

        // Grace restarted on re-entry R: fan drops at R+2, FAULT_MIT at R+17.
        $display("[TB] fan grace window");
        tick(2);
        applyStimulus(4'hB, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(14);
        checkOutput("grace16_state", {5'd0, state}, 8'd1);
        tick(1);
        checkOutput("grace17_state", {5'd0, state}, 8'd2);
        checkOutput("faultmit_outs", {2'd0, outs}, 8'b00101111);

        // Asynchronous reset between edges from FAULT_MIT.
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst1_state", {5'd0, state}, 8'd0);
        checkOutput("arst1_outs", {2'd0, outs}, 8'd0);
        checkOutput("arst1_mask", {4'd0, zoneMask}, 8'd0);
        tick(1);
        rst = 1'b0;

        // Escalation: zone 3 temperature hazard held with plant OK.
        $display("[TB] escalation");
        applyStimulus(4'hF, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(9);
        checkOutput("esc_entry_state", {5'd0, state}, 8'd1);
        checkOutput("esc_entry_mask", {4'd0, zoneMask}, 8'b00001000);
        tick(63);
        checkOutput("esc_cyc64_outs", {2'd0, outs}, 8'b00101101);
        tick(1);
        checkOutput("esc_cyc65_outs", {2'd0, outs}, 8'b00101111);

        // Sensors clear: WAIT_RESET 9 edges later, remote alert held.
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(8);
        checkOutput("clear8_state", {5'd0, state}, 8'd1);
        tick(1);
        checkOutput("wait_state", {5'd0, state}, 8'd3);
        checkOutput("wait_outs", {2'd0, outs}, 8'b00000111);
        checkOutput("wait_mask", {4'd0, zoneMask}, 8'b00001000);

        // Zone 1 re-hazards in WAIT_RESET; badge then present but ignored.
        applyStimulus(4'hD, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(8);
        checkOutput("rehaz8_state", {5'd0, state}, 8'd3);
        applyStimulus(4'hD, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(1);
        checkOutput("rfid_haz_state", {5'd0, state}, 8'd1);
        checkOutput("rfid_haz_outs", {2'd0, outs}, 8'b00101111);
        checkOutput("rfid_haz_mask", {4'd0, zoneMask}, 8'b00001010);

        // Asynchronous reset mid-HAZARD.
        $display("[TB] async reset mid-hazard");
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst2_state", {5'd0, state}, 8'd0);
        checkOutput("arst2_outs", {2'd0, outs}, 8'd0);
        checkOutput("arst2_mask", {4'd0, zoneMask}, 8'd0);
        tick(1);
        rst = 1'b0;

        // Fresh hazard: full debounce again and escalation cleared.
        applyStimulus(4'hE, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(8);
        checkOutput("post_rst_deb8", {5'd0, state}, 8'd0);
        tick(1);
        checkOutput("post_rst_state", {5'd0, state}, 8'd1);
        checkOutput("post_rst_outs", {2'd0, outs}, 8'b00101101);
        checkOutput("post_rst_mask", {4'd0, zoneMask}, 8'b00000001);
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(9);
        checkOutput("wait2_state", {5'd0, state}, 8'd3);
        checkOutput("wait2_outs", {2'd0, outs}, 8'b00000101);

        // Authorised reset with all zones safe.
        $display("[TB] badge reset and standby power fail");
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(1);
        checkOutput("badge_state", {5'd0, state}, 8'd0);
        checkOutput("badge_outs", {2'd0, outs}, 8'd0);
        checkOutput("badge_mask", {4'd0, zoneMask}, 8'd0);

        // Power fail from STANDBY and recovery.
        applyStimulus(4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("fspf_state", {5'd0, state}, 8'd4);
        checkOutput("fspf_outs", {2'd0, outs}, 8'b00010000);
        applyStimulus(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("fspf_back_state", {5'd0, state}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
